axis_master_bfm: RTL and testbench

//  Synthesizable AXI4-Stream master traffic generator for block-level benches.

---
 rtl/axis_pkg.sv | 30 +++
 rtl/axis_if.sv | 28 ++
 rtl/axis_master_bfm.sv | 137 +++++++++++++
 tb/tb_axis_master_bfm.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types for the AXI4-Stream traffic generator: FSM states, default widths
// and a beat record, plus a helper that builds the active-byte mask.
package axis_pkg;

  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned AXIS_STRB_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } axis_state_e;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_STRB_W-1:0] tstrb;
    logic [AXIS_STRB_W-1:0] tkeep;
    logic                   tlast;
    logic                   tid;
    logic                   tdest;
    logic                   tuser;
  } axis_beat_t;

  // Low nbytes bits set; callers cast down to their strobe width.
  function automatic logic [63:0] active_mask(input int unsigned nbytes);
    return (64'd1 << nbytes) - 64'd1;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI4-Stream signal bundle with master and slave views.
interface axis_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STRB_W = 8
) (
  input logic aclk,
  input logic aresetn
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [STRB_W-1:0] tstrb;
  logic [STRB_W-1:0] tkeep;
  logic              tlast;
  logic              tid;
  logic              tdest;
  logic              tuser;

  modport master (
    input  aclk, aresetn, tready,
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser
  );

  modport slave (
    input  aclk, aresetn, tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_master_bfm.sv
// AXI4-Stream master traffic generator: packets of incrementing words with
// optional inter-packet gaps and an optional packet limit.
module axis_master_bfm
  import axis_pkg::*;
#(
  parameter int unsigned       DATA_W     = AXIS_DATA_W,
  parameter int unsigned       STRB_W     = AXIS_STRB_W,
  parameter int unsigned       PKT_LEN    = 4,
  parameter int unsigned       NUM_PKTS   = 0,
  parameter int unsigned       GAP_CYCLES = 1,
  parameter logic [DATA_W-1:0] START_VAL  = '0
) (
  input  logic              aclk,
  input  logic              aresetn,
  output logic              tvalid,
  input  logic              tready,
  output logic [DATA_W-1:0] tdata,
  output logic [STRB_W-1:0] tstrb,
  output logic [STRB_W-1:0] tkeep,
  output logic              tlast,
  output logic              tid,
  output logic              tdest,
  output logic              tuser,
  output logic              done
);

  localparam logic [31:0]       LAST_IDX      = 32'(PKT_LEN - 1);
  localparam logic [31:0]       NUM_LIM       = 32'(NUM_PKTS);
  localparam logic [31:0]       GAP_LAST      = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
  localparam logic [STRB_W-1:0] ACTIVE_MASK   = STRB_W'(active_mask(DATA_W / 8));
  localparam logic              FIRST_IS_LAST = (PKT_LEN == 1);

  axis_state_e       state_q;
  logic              tvalid_q;
  logic [DATA_W-1:0] tdata_q;
  logic [STRB_W-1:0] strb_q;
  logic              tlast_q;
  logic              tuser_q;
  logic              done_q;
  logic [31:0]       beat_q;
  logic [31:0]       pkt_q;
  logic [31:0]       gap_q;

  logic [DATA_W-1:0] tdata_d;
  logic [31:0]       beat_d;
  logic [31:0]       pkt_d;
  logic              pkt_full;

  assign tdata_d  = tdata_q + DATA_W'(1);
  assign beat_d   = beat_q + 32'd1;
  assign pkt_d    = pkt_q + 32'd1;
  assign pkt_full = (NUM_PKTS != 0) && (pkt_d == NUM_LIM);

  // All outputs are registered; in SEND tvalid is 1, so tready alone qualifies a transfer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      tvalid_q <= 1'b0;
      tdata_q  <= START_VAL;
      strb_q   <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      done_q   <= 1'b0;
      beat_q   <= '0;
      pkt_q    <= '0;
      gap_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q  <= SEND;
          tvalid_q <= 1'b1;
          strb_q   <= ACTIVE_MASK;
          tuser_q  <= 1'b1;
          tlast_q  <= FIRST_IS_LAST;
          beat_q   <= '0;
        end
        SEND: begin
          if (tready) begin
            tdata_q <= tdata_d;
            if (beat_q == LAST_IDX) begin
              beat_q <= '0;
              if (NUM_PKTS != 0) pkt_q <= pkt_d;
              if (pkt_full) begin
                state_q  <= DONE;
                tvalid_q <= 1'b0;
                strb_q   <= '0;
                tlast_q  <= 1'b0;
                tuser_q  <= 1'b0;
                done_q   <= 1'b1;
              end else if (GAP_CYCLES != 0) begin
                state_q  <= GAP;
                gap_q    <= GAP_LAST;
                tvalid_q <= 1'b0;
                strb_q   <= '0;
                tlast_q  <= 1'b0;
                tuser_q  <= 1'b0;
              end else begin
                tuser_q <= 1'b1;
                tlast_q <= FIRST_IS_LAST;
              end
            end else begin
              beat_q  <= beat_d;
              tuser_q <= 1'b0;
              tlast_q <= (beat_d == LAST_IDX);
            end
          end
        end
        GAP: begin
          if (gap_q == 32'd0) begin
            state_q  <= SEND;
            tvalid_q <= 1'b1;
            strb_q   <= ACTIVE_MASK;
            tuser_q  <= 1'b1;
            tlast_q  <= FIRST_IS_LAST;
          end else begin
            gap_q <= gap_q - 32'd1;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tvalid = tvalid_q;
  assign tdata  = tdata_q;
  assign tstrb  = strb_q;
  assign tkeep  = strb_q;
  assign tlast  = tlast_q;
  assign tid    = 1'b0;
  assign tdest  = 1'b0;
  assign tuser  = tuser_q;
  assign done   = done_q;

endmodule

// File: tb/tb_axis_master_bfm.sv
// Bench for axis_master_bfm: three configurations checked cycle by cycle against
// a beat-index model of the expected stream.
module tb_axis_master_bfm;

  logic aclk = 1'b0;
  always #10 aclk = ~aclk;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
  logic rdy_a = 1'b0, rdy_b = 1'b0, rdy_c = 1'b0;

  logic        va, vb, vc, la, lb, lc, ua, ub, uc, ia, ib, ic, ea, eb, ec, na, nb, nc;
  logic [31:0] da, db, dc;
  logic [7:0]  sa, sb, sc, ka, kb, kc;

  axis_master_bfm u_a (
    .aclk(aclk), .aresetn(rst_a), .tvalid(va), .tready(rdy_a), .tdata(da), .tstrb(sa),
    .tkeep(ka), .tlast(la), .tid(ia), .tdest(ea), .tuser(ua), .done(na)
  );

  axis_master_bfm #(.PKT_LEN(3), .NUM_PKTS(2), .GAP_CYCLES(1)) u_b (
    .aclk(aclk), .aresetn(rst_b), .tvalid(vb), .tready(rdy_b), .tdata(db), .tstrb(sb),
    .tkeep(kb), .tlast(lb), .tid(ib), .tdest(eb), .tuser(ub), .done(nb)
  );

  axis_master_bfm #(.PKT_LEN(1), .GAP_CYCLES(0), .START_VAL(32'hFFFF_FFFE)) u_c (
    .aclk(aclk), .aresetn(rst_c), .tvalid(vc), .tready(rdy_c), .tdata(dc), .tstrb(sc),
    .tkeep(kc), .tlast(lc), .tid(ic), .tdest(ec), .tuser(uc), .done(nc)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [7:0]  strb;
    logic [7:0]  keep;
    logic        last;
    logic        id;
    logic        dest;
    logic        user;
    logic        done;
  } obs_t;

  int checks = 0;
  int failures = 0;

  // Model: stream is fully determined by beats transferred (m_k), packets completed,
  // and the number of tvalid=0 cycles still owed (after release or between packets).
  int unsigned m_plen, m_num, m_gap;
  logic [31:0] m_start;
  int unsigned m_k, m_pkts, m_idle;
  bit          m_done;
  int unsigned obs_xfers;

  function automatic obs_t sample(input int sel);
    obs_t o;
    case (sel)
      0: o = '{va, da, sa, ka, la, ia, ea, ua, na};
      1: o = '{vb, db, sb, kb, lb, ib, eb, ub, nb};
      default: o = '{vc, dc, sc, kc, lc, ic, ec, uc, nc};
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_rdy(input int sel, input logic r);
    case (sel)
      0: rdy_a = r;
      1: rdy_b = r;
      default: rdy_c = r;
    endcase
  endtask

  task automatic drive_rst(input int sel, input logic r);
    case (sel)
      0: rst_a = r;
      1: rst_b = r;
      default: rst_c = r;
    endcase
  endtask

  // Called at a falling edge with reset asserted: checks reset values, then releases.
  task automatic start(input int sel, input int unsigned plen, input int unsigned num,
                       input int unsigned gap, input logic [31:0] sv);
    obs_t o;
    m_plen = plen; m_num = num; m_gap = gap; m_start = sv;
    m_k = 0; m_pkts = 0; m_idle = 1; m_done = 0; obs_xfers = 0;
    drive_rdy(sel, 1'b0);
    o = sample(sel);
    chk("rst_tvalid", 32'(o.valid), 32'd0);
    chk("rst_tdata", o.data, sv);
    chk("rst_tstrb", 32'(o.strb), 32'd0);
    chk("rst_tkeep", 32'(o.keep), 32'd0);
    chk("rst_tlast", 32'(o.last), 32'd0);
    chk("rst_tuser", 32'(o.user), 32'd0);
    chk("rst_done", 32'(o.done), 32'd0);
    drive_rst(sel, 1'b1);
  endtask

  // One clock cycle: compare the mid-cycle outputs, drive tready, advance the model.
  task automatic cyc(input int sel, input logic r);
    obs_t o;
    logic exp_v;
    int unsigned idx;
    exp_v = !m_done && (m_idle == 0);
    idx   = m_k % m_plen;
    o = sample(sel);
    chk("tvalid", 32'(o.valid), 32'(exp_v));
    chk("done", 32'(o.done), 32'(m_done));
    chk("tid_tdest", {30'd0, o.id, o.dest}, 32'd0);
    if (exp_v) begin
      chk("tdata", o.data, m_start + m_k);
      chk("tlast", 32'(o.last), 32'(idx == m_plen - 1));
      chk("tuser", 32'(o.user), 32'(idx == 0));
      chk("tstrb", 32'(o.strb), 32'h0F);
      chk("tkeep", 32'(o.keep), 32'h0F);
    end else begin
      chk("tstrb_idle", 32'(o.strb), 32'd0);
      chk("tkeep_idle", 32'(o.keep), 32'd0);
    end
    drive_rdy(sel, r);
    #1;
    o = sample(sel);
    chk("tvalid_vs_tready", 32'(o.valid), 32'(exp_v));
    if (o.valid && r) obs_xfers++;
    if (!m_done && m_idle > 0) begin
      m_idle--;
    end else if (exp_v && r) begin
      m_k++;
      if (idx == m_plen - 1) begin
        m_pkts++;
        if (m_num != 0 && m_pkts == m_num) m_done = 1;
        else m_idle = m_gap;
      end
    end
    @(negedge aclk);
  endtask

  initial begin
    obs_t o;
    bit hit;
    repeat (3) @(negedge aclk);

    // Stalled start, then streaming with a one-cycle gap between packets.
    start(0, 4, 0, 1, 32'd0);
    repeat (6) cyc(0, 1'b0);
    repeat (14) cyc(0, 1'b1);

    // Random backpressure.
    for (int i = 0; i < 200; i++) cyc(0, 1'($urandom_range(0, 1)));

    // Async reset while beat index 2 is presented.
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (!m_done && m_idle == 0 && (m_k % m_plen) == 2) hit = 1;
      else cyc(0, 1'b1);
    end
    chk("reach_beat2", 32'(hit), 32'd1);
    #3 rst_a = 1'b0;
    #1;
    o = sample(0);
    chk("async_tvalid", 32'(o.valid), 32'd0);
    chk("async_tdata", o.data, 32'd0);
    @(negedge aclk);
    start(0, 4, 0, 1, 32'd0);
    repeat (12) cyc(0, 1'b1);
    rst_a = 1'b0;

    // Packet limit: two packets of three beats.
    @(negedge aclk);
    start(1, 3, 2, 1, 32'd0);
    repeat (16) cyc(1, 1'b1);
    chk("limit_xfers", 32'(obs_xfers), 32'd6);
    o = sample(1);
    chk("limit_done", 32'(o.done), 32'd1);
    for (int i = 0; i < 10; i++) cyc(1, 1'($urandom_range(0, 1)));
    rst_b = 1'b0;

    // Data wrap with single-beat packets and no gaps.
    @(negedge aclk);
    start(2, 1, 0, 0, 32'hFFFF_FFFE);
    repeat (6) cyc(2, 1'b1);
    for (int i = 0; i < 40; i++) cyc(2, 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
